microwave_timer_ctrl: RTL and testbench
=======================================

Name: microwave_timer_ctrl

Overview:
- Sequencing controller for the microwave cook timer.
- Accepts keypad digit entry and the start/stop/clear buttons.
- Counts the entered M:SS time down once per second and drives the magnetron enable.
- Presents three BCD digits (min, sec_tens, sec_ones) that feed the three-digit 7-segment decoder directly.

Parameters:
- TICK_DIV, 50_000_000: clock cycles per one-second tick of the internal prescaler; must be ≥2.
- DONE_TICKS, 3: whole seconds spent in DONE (beep window) before the automatic return to IDLE.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- key_valid  in  1  one-cycle strobe: key_digit is valid
- key_digit  in  4  keypad value; only 0–9 legal
- start  in  1  one-cycle strobe, start/resume
- stop  in  1  one-cycle strobe, pause/cancel
- clear  in  1  one-cycle strobe, clear all
- door_closed  in  1  level, 1 = door closed
- min  out  4  BCD minutes digit, 0–9
- sec_tens  out  4  BCD tens-of-seconds digit, 0–5
- sec_ones  out  4  BCD seconds digit, 0–9
- magnetron_on  out  1  high only in RUN
- beep  out  1  high only in DONE
- done  out  1  one-cycle pulse when the count reaches 0:00
- state  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE
  - min, sec_tens and sec_ones = 0
  - magnetron_on, beep, done = 0
  - prescaler=0, done-tick counter=0
- All outputs are registered. The outputs update on the clock edge after the causing strobe.
- Strobe priority within a cycle: clear > stop > start > key_valid. Only the highest-priority strobe takes effect; the others are dropped.
- clear in any state: state=IDLE, all digits=0, prescaler=0.
- IDLE (entry):
  - A key_valid with key_digit≤9 shifts the digits left: min←sec_tens, sec_tens←sec_ones, sec_ones←key_digit. The old min is discarded.
  - The key is rejected (no change) if key_digit>9 or current sec_ones>5, so that sec_tens stays ≤5.
  - start with door_closed=1 and time≠0:00: go to RUN and reset the prescaler to 0.
  - Otherwise start is ignored.
  - stop in IDLE has the same effect as clear.
- RUN:
  - magnetron_on=1.
  - The prescaler counts 0..TICK_DIV-1; a tick occurs in the cycle where it equals TICK_DIV-1, and it wraps to 0.
  - The first decrement therefore occurs exactly TICK_DIV cycles after the start edge.
  - On a tick, BCD decrement:
    - if sec_ones>0: sec_ones−1
    - else if sec_tens>0: sec_ones=9, sec_tens−1
    - else: min−1, sec_tens=5, sec_ones=9
  - If the decrement produces 0:00, in the same edge: state=DONE, done=1 for one cycle, magnetron_on=0.
  - door_closed=0: go to PAUSE on the next edge. The prescaler value is frozen and digits are unchanged. Door-open has priority over a coincident tick, so no decrement happens.
  - stop: go to PAUSE. start: ignored. Keys: ignored.
- PAUSE:
  - magnetron_on=0; the prescaler holds its value.
  - start with door_closed=1: go to RUN and resume the prescaler from its held value.
  - stop: go to IDLE with digits cleared (cancel). Keys: ignored.
- DONE:
  - beep=1, digits=0:00, and the prescaler keeps running.
  - Each tick increments the done counter. At DONE_TICKS ticks: state=IDLE, beep=0, counter=0.
  - Any of key_valid, stop, clear or start exits to IDLE immediately; the key is not entered.
- Reset asserted mid-RUN: magnetron_on drops asynchronously, and all state returns to reset values.
- Digits never leave the legal BCD range. No X is driven on any output.

Test Plan:
- Entry and rejection, TICK_DIV=4:
  - keys 1,3,0 → min=1, sec_tens=3, sec_ones=0.
  - key 12 → no change.
  - With sec_ones=7, key 2 → no change.
  - A fourth key 5 on 1:30 → 3:05.
- Countdown with borrow:
  - Enter 1:00, start with door closed → magnetron_on=1, state=RUN.
  - After 4 cycles: 0:59. After a further 4 cycles: 0:58.
  - At 1:00 the borrow chain gives 0:59 from min borrow; 0:10 → 0:09.
- Completion:
  - Enter 0:02, start.
  - done pulses exactly once at 8 cycles after start, with digits 0:00 and state=DONE, beep=1.
  - After DONE_TICKS·TICK_DIV=12 cycles: state=IDLE, beep=0.
- Door and pause:
  - RUN at 0:30, door_closed→0 → PAUSE, magnetron_on=0, digits frozen.
  - start while door open → stays PAUSE.
  - Close the door, start → RUN, decrement after the remaining prescaler cycles.
  - stop in PAUSE → IDLE, 0:00.
- Priority and guards:
  - start+clear in the same cycle → IDLE, 0:00.
  - start at 0:00 → stays IDLE.
  - start with door open → stays IDLE.
  - Key during RUN → digits unaffected.
- Async reset:
  - Assert rst_n=0 mid-RUN between clock edges → magnetron_on=0 and all digits 0 immediately.
  - After release, a key entry works normally.

Source files
------------

// File: rtl/microwave_timer_ctrl.sv
// Microwave cook-timer sequencer: keypad M:SS entry, one-second BCD countdown,
// magnetron enable, door interlock and a timed beep window after completion.
module microwave_timer_ctrl #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int DONE_TICKS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       door_closed,
  output logic [3:0] min,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       magnetron_on,
  output logic       beep,
  output logic       done,
  output logic [1:0] state
);

  // Control inputs are single-cycle strobes sampled on the rising edge with no
  // back-pressure: clear > stop > start > key_valid, and only the highest
  // asserted strobe acts in a cycle even if that strobe is then ignored.

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DONE_TICKS + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DONE_LAST  = DW'(DONE_TICKS - 1);

  logic [PW-1:0] presc_q, presc_d, presc_inc;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [1:0]    state_d;
  logic [3:0]    min_d, tens_d, ones_d;
  logic [3:0]    dec_min, dec_tens, dec_ones;
  logic          done_d;
  logic          tick, time_zero, key_ok, dec_zero;

  assign tick      = (presc_q == PRESC_LAST);
  assign presc_inc = tick ? '0 : presc_q + 1'b1;
  assign time_zero = (min == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd0);
  // sec_ones must be a legal tens digit before it can be shifted into sec_tens.
  assign key_ok    = (key_digit <= 4'd9) && (sec_ones <= 4'd5);

  // One-second BCD decrement with borrow from tens and then minutes.
  always_comb begin
    dec_min  = min;
    dec_tens = sec_tens;
    dec_ones = sec_ones;
    if (sec_ones != 4'd0) begin
      dec_ones = sec_ones - 4'd1;
    end else if (sec_tens != 4'd0) begin
      dec_ones = 4'd9;
      dec_tens = sec_tens - 4'd1;
    end else if (min != 4'd0) begin
      dec_min  = min - 4'd1;
      dec_tens = 4'd5;
      dec_ones = 4'd9;
    end
  end

  assign dec_zero = (dec_min == 4'd0) && (dec_tens == 4'd0) && (dec_ones == 4'd0);

  always_comb begin
    state_d = state;
    min_d   = min;
    tens_d  = sec_tens;
    ones_d  = sec_ones;
    presc_d = presc_q;
    dcnt_d  = dcnt_q;
    done_d  = 1'b0;
    if (clear) begin
      state_d = IDLE;
      min_d   = 4'd0;
      tens_d  = 4'd0;
      ones_d  = 4'd0;
      presc_d = '0;
      dcnt_d  = '0;
    end else begin
      case (state)
        IDLE: begin
          presc_d = '0;
          dcnt_d  = '0;
          if (stop) begin
            min_d  = 4'd0;
            tens_d = 4'd0;
            ones_d = 4'd0;
          end else if (start) begin
            if (door_closed && !time_zero) state_d = RUN;
          end else if (key_valid && key_ok) begin
            min_d  = sec_tens;
            tens_d = sec_ones;
            ones_d = key_digit;
          end
        end
        RUN: begin
          // Door-open and stop both freeze the prescaler, even on a tick cycle.
          if (stop || !door_closed) begin
            state_d = PAUSE;
          end else begin
            presc_d = presc_inc;
            if (tick) begin
              min_d  = dec_min;
              tens_d = dec_tens;
              ones_d = dec_ones;
              if (dec_zero) begin
                state_d = DONE;
                done_d  = 1'b1;
                dcnt_d  = '0;
              end
            end
          end
        end
        PAUSE: begin
          if (stop) begin
            state_d = IDLE;
            min_d   = 4'd0;
            tens_d  = 4'd0;
            ones_d  = 4'd0;
            presc_d = '0;
          end else if (start && door_closed) begin
            state_d = RUN;
          end
        end
        DONE: begin
          if (stop || start || key_valid) begin
            state_d = IDLE;
            presc_d = '0;
            dcnt_d  = '0;
          end else begin
            presc_d = presc_inc;
            if (tick) begin
              if (dcnt_q == DONE_LAST) begin
                state_d = IDLE;
                dcnt_d  = '0;
              end else begin
                dcnt_d = dcnt_q + 1'b1;
              end
            end
          end
        end
        default: begin
          state_d = IDLE;
          min_d   = 4'd0;
          tens_d  = 4'd0;
          ones_d  = 4'd0;
          presc_d = '0;
          dcnt_d  = '0;
        end
      endcase
    end
  end

  // Output flags are registered from the next state so they change with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      min          <= 4'd0;
      sec_tens     <= 4'd0;
      sec_ones     <= 4'd0;
      presc_q      <= '0;
      dcnt_q       <= '0;
      magnetron_on <= 1'b0;
      beep         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_d;
      min          <= min_d;
      sec_tens     <= tens_d;
      sec_ones     <= ones_d;
      presc_q      <= presc_d;
      dcnt_q       <= dcnt_d;
      magnetron_on <= (state_d == RUN);
      beep         <= (state_d == DONE);
      done         <= done_d;
    end
  end

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Bench for microwave_timer_ctrl: directed scenarios plus random strobes, with a
// remaining-seconds reference model feeding an expected-output queue.
module tb_microwave_timer_ctrl;
  localparam int TICK_DIV   = 4;
  localparam int DONE_TICKS = 3;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clear = 1'b0;
  logic       door_closed = 1'b1;
  logic [3:0] min, sec_tens, sec_ones;
  logic       magnetron_on, beep, done;
  logic [1:0] state;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the cook time is held as total remaining seconds.
  int m_state, m_secs, m_phase, m_done_secs;
  bit m_done;
  logic [16:0] exp_q[$];

  microwave_timer_ctrl #(.TICK_DIV(TICK_DIV), .DONE_TICKS(DONE_TICKS)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_digit(key_digit),
    .start(start), .stop(stop), .clear(clear), .door_closed(door_closed),
    .min(min), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .magnetron_on(magnetron_on), .beep(beep), .done(done), .state(state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = S_IDLE; m_secs = 0; m_phase = 0; m_done_secs = 0; m_done = 0;
  endtask

  task automatic model_step();
    int so;
    m_done = 0;
    so = m_secs % 10;
    if (clear) begin
      m_state = S_IDLE; m_secs = 0; m_phase = 0; m_done_secs = 0;
    end else begin
      case (m_state)
        S_IDLE: begin
          if (stop) m_secs = 0;
          else if (start) begin
            if (door_closed && m_secs > 0) begin m_state = S_RUN; m_phase = 0; end
          end else if (key_valid && key_digit <= 9 && so <= 5)
            m_secs = ((m_secs % 60) / 10) * 60 + so * 10 + int'(key_digit);
        end
        S_RUN: begin
          if (stop || !door_closed) m_state = S_PAUSE;
          else if (m_phase == TICK_DIV - 1) begin
            m_phase = 0;
            m_secs--;
            if (m_secs == 0) begin m_state = S_DONE; m_done = 1; m_done_secs = 0; end
          end else m_phase++;
        end
        S_PAUSE: begin
          if (stop) begin m_state = S_IDLE; m_secs = 0; m_phase = 0; end
          else if (start && door_closed) m_state = S_RUN;
        end
        default: begin
          if (key_valid || stop || start) begin
            m_state = S_IDLE; m_phase = 0; m_done_secs = 0;
          end else if (m_phase == TICK_DIV - 1) begin
            m_phase = 0;
            m_done_secs++;
            if (m_done_secs == DONE_TICKS) begin m_state = S_IDLE; m_done_secs = 0; end
          end else m_phase++;
        end
      endcase
    end
  endtask

  function automatic logic [16:0] model_outputs();
    return {2'(m_state), 4'(m_secs / 60), 4'((m_secs % 60) / 10), 4'(m_secs % 10),
            m_state == S_RUN, m_state == S_DONE, m_done};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic compare_outputs();
    logic [16:0] e;
    e = exp_q.pop_front();
    check("state", state, e[16:15]);
    check("min", min, e[14:11]);
    check("sec_tens", sec_tens, e[10:7]);
    check("sec_ones", sec_ones, e[6:3]);
    check("magnetron_on", magnetron_on, e[2]);
    check("beep", beep, e[1]);
    check("done", done, e[0]);
  endtask

  task automatic step_cycle();
    @(posedge clk);
    model_step();
    exp_q.push_back(model_outputs());
    @(negedge clk);
    compare_outputs();
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic kv, input logic [3:0] kd, input logic st,
                       input logic sp, input logic cl, input logic dc);
    key_valid = kv; key_digit = kd; start = st; stop = sp; clear = cl; door_closed = dc;
    step_cycle();
    key_valid = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, door_closed);
  endtask

  task automatic key(input logic [3:0] d);
    drive(1'b1, d, 1'b0, 1'b0, 1'b0, door_closed);
  endtask

  task automatic press_start();
    drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, door_closed);
  endtask

  task automatic press_stop();
    drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, door_closed);
  endtask

  task automatic press_clear();
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, door_closed);
  endtask

  task automatic check_time(input string tag, input int m, input int t, input int o);
    check({tag, "_min"}, min, m);
    check({tag, "_tens"}, sec_tens, t);
    check({tag, "_ones"}, sec_ones, o);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int dn;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_state", state, S_IDLE);
    check_time("rst", 0, 0, 0);
    check("rst_mag", magnetron_on, 0);
    check("rst_beep", beep, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;

    // Entry and rejection
    key(4'd1); key(4'd3); key(4'd0);
    check_time("entry", 1, 3, 0);
    key(4'd12);
    check_time("key12", 1, 3, 0);
    key(4'd5);
    check_time("shift4", 3, 0, 5);
    press_clear(); key(4'd7); key(4'd2);
    check_time("ones7", 0, 0, 7);

    // Countdown with borrow
    press_clear(); key(4'd1); key(4'd0); key(4'd0);
    press_start();
    check("run_state", state, S_RUN);
    check("run_mag", magnetron_on, 1);
    idle(3);
    check_time("pre_tick", 1, 0, 0);
    idle(1);
    check_time("borrow_min", 0, 5, 9);
    key(4'd3);
    check_time("key_in_run", 0, 5, 9);
    idle(3);
    check_time("tick2", 0, 5, 8);
    press_clear(); key(4'd1); key(4'd0); press_start(); idle(4);
    check_time("borrow_tens", 0, 0, 9);
    press_clear();

    // Completion
    key(4'd2); press_start();
    dn = 0;
    for (int c = 1; c <= 20; c++) begin
      idle(1);
      if (done) dn++;
      if (c == 8) begin
        check("done_at8", done, 1);
        check("done_state", state, S_DONE);
        check("done_beep", beep, 1);
        check_time("done", 0, 0, 0);
      end
      if (c == 19) check("beep_window", state, S_DONE);
    end
    check("done_once", dn, 1);
    check("auto_idle", state, S_IDLE);
    check("auto_beep", beep, 0);

    // Door and pause
    key(4'd3); key(4'd0); press_start(); idle(2);
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("door_pause", state, S_PAUSE);
    check("door_mag", magnetron_on, 0);
    check_time("door", 0, 3, 0);
    press_start();
    check("start_door_open", state, S_PAUSE);
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    press_start();
    check("resume", state, S_RUN);
    idle(1);
    check_time("resume1", 0, 3, 0);
    idle(1);
    check_time("resume2", 0, 2, 9);
    press_stop();
    check("stop_run", state, S_PAUSE);
    press_stop();
    check("cancel", state, S_IDLE);
    check_time("cancel", 0, 0, 0);

    // Priority and guards
    key(4'd5);
    drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    check("start_clear", state, S_IDLE);
    check_time("start_clear", 0, 0, 0);
    press_start();
    check("start_zero", state, S_IDLE);
    key(4'd5);
    drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("start_open", state, S_IDLE);
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Async reset mid-RUN
    press_start(); idle(2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_mag", magnetron_on, 0);
    check("arst_state", state, S_IDLE);
    check_time("arst", 0, 0, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    key(4'd4);
    check_time("post_rst", 0, 0, 4);

    // Random: short cook times with door blips and stray strobes
    for (int t = 0; t < 40; t++) begin
      press_clear();
      key(4'($urandom_range(1, 9)));
      press_start();
      for (int c = 0; c < 50; c++)
        drive($urandom_range(0, 99) < 5, 4'($urandom_range(0, 11)),
              $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 2,
              $urandom_range(0, 99) < 1, $urandom_range(0, 99) < 95);
    end

    // Random: free-running strobes
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 99) < 25, 4'($urandom_range(0, 11)),
            $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 3,
            $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 90);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
